// File: rtl/counter_sat_multi.sv
// Multi-channel saturating event counter: counts rising edges (EDGE=1) or high cycles (EDGE=0)
// of trig[i], holding at MAXVAL with a sticky sat flag. Define CNT_THRESH_EN for thresh/over.
module counter_sat_multi #(
   parameter int unsigned     NCH    = 4,
   parameter int unsigned     WIDTH  = 8,
   parameter int unsigned     EDGE   = 1,
   parameter longint unsigned MAXVAL = (64'd1 << WIDTH) - 64'd1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NCH-1:0]       trig,
   input  logic [NCH-1:0]       clear,
`ifdef CNT_THRESH_EN
   input  logic [WIDTH-1:0]     thresh,
   output logic [NCH-1:0]       over,
`endif
   output logic [NCH*WIDTH-1:0] count,
   output logic [NCH-1:0]       sat,
   output logic                 any_sat
);

   localparam longint unsigned MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAXVAL);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic             EDGE_MODE = (EDGE != 0);

   generate
      if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
         $error("counter_sat_multi: WIDTH %0d outside 1..63", WIDTH);
      end
      if (MAXVAL == 0 || MAXVAL > MAX_LEGAL) begin : g_bad_maxval
         $error("counter_sat_multi: MAXVAL %0d outside 1..%0d", MAXVAL, MAX_LEGAL);
      end
   endgenerate

   logic [NCH-1:0]   trig_q;
   logic [NCH-1:0]   ev;
   logic [NCH-1:0]   below;
   logic [NCH-1:0]   inc;
   logic [NCH-1:0]   sat_d;
   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];

   // Level mode simply masks the history term, so trig_q exists in both modes.
   assign ev  = trig & ~(trig_q & {NCH{EDGE_MODE}});
   assign inc = ~clear & ev & below & {NCH{enable}};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      below = '0;
      sat_d = sat;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         below[i] = (cnt_q[i] < MAX_W);
         if (clear[i]) begin
            cnt_d[i] = '0;
            sat_d[i] = 1'b0;
         end else if (inc[i]) begin
            cnt_d[i] = cnt_q[i] + ONE;
            if (cnt_d[i] == MAX_W) begin
               sat_d[i] = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trig_q  <= '0;
         sat     <= '0;
         any_sat <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         trig_q  <= trig;
         sat     <= sat_d;
         any_sat <= |sat_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_pack
         assign count[g*WIDTH +: WIDTH] = cnt_q[g];
      end
   endgenerate

`ifdef CNT_THRESH_EN
   logic [NCH-1:0] over_d;

   // Pulse only on an increment that lands on thresh; holds, saturation and clears never pulse.
   always_comb begin
      over_d = '0;
      for (int i = 0; i < NCH; i++) begin
         over_d[i] = inc[i] && (thresh != '0) && (cnt_d[i] == thresh);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         over <= '0;
      end else begin
         over <= over_d;
      end
   end
`endif

endmodule

// File: tb/tb_counter_sat_multi.sv
// Bench for counter_sat_multi: an edge-mode instance (WIDTH=2, MAXVAL=3) and a level-mode
// instance (WIDTH=3, MAXVAL=5) share stimulus; a table, hand sequences and a random phase.
module tb_counter_sat_multi;
   localparam int NCH = 4;
   localparam int WE  = 2;
   localparam int ME  = 3;
   localparam int WL  = 3;
   localparam int ML  = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic [NCH-1:0]      trig;
   logic [NCH-1:0]      clear;
   logic [NCH*WE-1:0]   count_e;
   logic [NCH-1:0]      sat_e;
   logic                any_e;
   logic [NCH*WL-1:0]   count_l;
   logic [NCH-1:0]      sat_l;
   logic                any_l;
`ifdef CNT_THRESH_EN
   int                  thresh_v = 0;
   logic [WE-1:0]       thresh_e;
   logic [WL-1:0]       thresh_l;
   logic [NCH-1:0]      over_e;
   logic [NCH-1:0]      over_l;
   assign thresh_e = WE'(thresh_v);
   assign thresh_l = WL'(thresh_v);
`endif

   always #5 clk = ~clk;

   counter_sat_multi #(.NCH(NCH), .WIDTH(WE), .EDGE(1), .MAXVAL(ME)) dut_e (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .trig    (trig),
      .clear   (clear),
`ifdef CNT_THRESH_EN
      .thresh  (thresh_e),
      .over    (over_e),
`endif
      .count   (count_e),
      .sat     (sat_e),
      .any_sat (any_e)
   );

   counter_sat_multi #(.NCH(NCH), .WIDTH(WL), .EDGE(0), .MAXVAL(ML)) dut_l (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .trig    (trig),
      .clear   (clear),
`ifdef CNT_THRESH_EN
      .thresh  (thresh_l),
      .over    (over_l),
`endif
      .count   (count_l),
      .sat     (sat_l),
      .any_sat (any_l)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: plain integer tallies per instance (0 = edge, 1 = level).
   int maxv  [2] = '{ME, ML};
   bit edgem [2] = '{1'b1, 1'b0};
   int m_cnt [2][NCH];
   bit m_sat [2][NCH];
   bit m_prev[2][NCH];
   bit m_over[2][NCH];

   task automatic model_clear_all();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[d][c] = 0; m_sat[d][c] = 0; m_prev[d][c] = 0; m_over[d][c] = 0;
         end
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         model_clear_all();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            bit ev;
            ev = edgem[d] ? (trig[c] && !m_prev[d][c]) : trig[c];
            m_over[d][c] = 0;
            if (clear[c]) begin
               m_cnt[d][c] = 0;
               m_sat[d][c] = 0;
            end else if (enable && ev && m_cnt[d][c] < maxv[d]) begin
               m_cnt[d][c] = m_cnt[d][c] + 1;
               if (m_cnt[d][c] == maxv[d]) m_sat[d][c] = 1;
`ifdef CNT_THRESH_EN
               if (thresh_v != 0 && m_cnt[d][c] == thresh_v) m_over[d][c] = 1;
`endif
            end
            m_prev[d][c] = trig[c];
         end
      end
   endtask

   task automatic compare_model();
      bit or_e, or_l;
      or_e = 0; or_l = 0;
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("edge cnt ch%0d", c), 32'(count_e[c*WE +: WE]), 32'(m_cnt[0][c]));
         check($sformatf("level cnt ch%0d", c), 32'(count_l[c*WL +: WL]), 32'(m_cnt[1][c]));
         check($sformatf("edge sat ch%0d", c), 32'(sat_e[c]), 32'(m_sat[0][c]));
         check($sformatf("level sat ch%0d", c), 32'(sat_l[c]), 32'(m_sat[1][c]));
`ifdef CNT_THRESH_EN
         check($sformatf("edge over ch%0d", c), 32'(over_e[c]), 32'(m_over[0][c]));
         check($sformatf("level over ch%0d", c), 32'(over_l[c]), 32'(m_over[1][c]));
`endif
         or_e |= m_sat[0][c];
         or_l |= m_sat[1][c];
      end
      check("edge any_sat", 32'(any_e), 32'(or_e));
      check("level any_sat", 32'(any_l), 32'(or_l));
   endtask

   // Inputs change at negedge; model and DUT both see them at the following posedge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   typedef struct {
      logic [NCH-1:0]    trig;
      logic [NCH-1:0]    clear;
      logic              en;
      logic [NCH*WE-1:0] exp_count;
      logic [NCH-1:0]    exp_sat;
      logic              exp_any;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'b0001, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0};
      tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0};
      tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 8'h02, 4'b0000, 1'b0};
      tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 8'h02, 4'b0000, 1'b0};
      tbl[4]  = '{4'b0001, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[6]  = '{4'b0001, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[8]  = '{4'b0001, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 8'h03, 4'b0001, 1'b1};
      tbl[10] = '{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0000, 1'b0};
      tbl[11] = '{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0};
      tbl[12] = '{4'b0001, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0};
      tbl[13] = '{4'b0010, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0};
      tbl[14] = '{4'b0000, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0};
      tbl[15] = '{4'b0010, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0};
      tbl[16] = '{4'b0000, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0};
      tbl[17] = '{4'b0010, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0};
      tbl[18] = '{4'b0010, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0};
      tbl[19] = '{4'b0000, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0};
      tbl[20] = '{4'b0010, 4'b0000, 1'b1, 8'h05, 4'b0000, 1'b0};
      tbl[21] = '{4'b0000, 4'b0001, 1'b0, 8'h04, 4'b0000, 1'b0};

      // Reset held for 3 clocks, then 10 idle clocks after release.
      reset = 1'b0; enable = 1'b1; trig = '0; clear = '0;
      model_clear_all();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset count", 32'(count_e), 32'd0);
         check("reset sat", 32'({sat_e, any_e}), 32'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle count", 32'(count_e), 32'd0);
         check("idle sat", 32'({sat_e, any_e}), 32'd0);
      end

      // Saturation, clear-vs-edge, enable gating, clear while disabled.
      for (int i = 0; i < 22; i++) begin
         trig = tbl[i].trig; clear = tbl[i].clear; enable = tbl[i].en;
         tick();
         check($sformatf("tbl[%0d] count", i), 32'(count_e), 32'(tbl[i].exp_count));
         check($sformatf("tbl[%0d] sat", i), 32'(sat_e), 32'(tbl[i].exp_sat));
         check($sformatf("tbl[%0d] any_sat", i), 32'(any_e), 32'(tbl[i].exp_any));
      end

      // Level mode: trig[2] high counts every cycle and holds at MAXVAL=5.
      trig = '0; clear = '1; enable = 1'b1;
      tick();
      clear = '0; trig = 4'b0100;
      for (int i = 0; i < 4; i++) tick();
      check("level 4 cycles", 32'(count_l[2*WL +: WL]), 32'd4);
      check("level not sat", 32'(sat_l[2]), 32'd0);
      tick(); tick();
      check("level ceiling", 32'(count_l[2*WL +: WL]), 32'd5);
      check("level sat", 32'(sat_l[2]), 32'd1);

      // Asynchronous reset between edges with count[0]=2.
      trig = '0; clear = '1;
      tick();
      clear = '0;
      trig = 4'b0001; tick();
      trig = 4'b0000; tick();
      trig = 4'b0001; tick();
      check("pre-reset count", 32'(count_e[1:0]), 32'd2);
      trig = 4'b0000;
      #1 reset = 1'b0;
      #1;
      check("async reset count", 32'(count_e), 32'd0);
      check("async reset sat", 32'({sat_e, any_e}), 32'd0);
      model_clear_all();
      tick();
      reset = 1'b1;
      trig = 4'b0001; tick();
      check("post-reset count", 32'(count_e[1:0]), 32'd1);

`ifdef CNT_THRESH_EN
      // Threshold pulse: exactly one over[3] when count[3] becomes 2, none with thresh=0.
      begin
         bit exp_over[7] = '{0, 0, 1, 0, 0, 0, 0};
         trig = '0; clear = '1; tick();
         clear = '0; thresh_v = 2;
         for (int i = 0; i < 7; i++) begin
            trig = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            check($sformatf("over thresh2 step%0d", i), 32'(over_e[3]), 32'(exp_over[i]));
         end
         trig = '0; clear = '1; thresh_v = 0; tick();
         clear = '0;
         for (int i = 0; i < 6; i++) begin
            trig = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            check($sformatf("over thresh0 step%0d", i), 32'(over_e), 32'd0);
         end
      end
`endif

      // Randomized phase against the model.
      for (int i = 0; i < 400; i++) begin
         trig   = NCH'($urandom);
         clear  = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
         enable = ($urandom_range(0, 7) != 0);
`ifdef CNT_THRESH_EN
         if ($urandom_range(0, 31) == 0) thresh_v = $urandom_range(0, 3);
`endif
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/counter_sat_multi.md
Name: counter_sat_multi

Overview:
Parametrised multi-channel saturating event counter. Successor to the 2-bit non-overflowing counter, generalised in width, channel count and count mode. Each channel counts trig events, either rising edges or high cycles, and holds at a ceiling instead of wrapping. Intended for PRBS/LED error and event tallies where a wrapped count would be misread as a low error rate.

Parameters:
NCH, 4, number of independent channels
WIDTH, 8, counter width per channel in bits
EDGE, 1, 1 = count rising edges of trig[i]; 0 = count every clk cycle trig[i] is high
MAXVAL, 2**WIDTH-1, saturation ceiling; legal range 1 .. 2**WIDTH-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  global count enable; events are ignored while low
trig  in  NCH  per-channel event inputs, synchronous to clk
clear  in  NCH  per-channel synchronous clear
count  out  NCH*WIDTH  packed counts; channel i at bits [i*WIDTH +: WIDTH]
sat  out  NCH  per-channel saturated flag, registered
any_sat  out  1  OR-reduction of sat, registered

Behaviour:
- Reset (reset=0) acts asynchronously with no clock edge needed:
  - count=0, sat=0, any_sat=0, edge register trig_q=0.
  - Outputs remain at these values for as long as reset is low.
- Edge register: trig_q[i] <= trig[i] every clk cycle while out of reset, regardless of enable.
- Event definition:
  - EDGE=1: ev[i] = trig[i] & ~trig_q[i].
  - EDGE=0: ev[i] = trig[i].
  - Because trig_q resets to 0, a trig held high across reset release counts as one edge on the first clock.
- Per-channel update on each clk rising edge, in priority order:
  1. clear[i]=1: count[i] <= 0, sat[i] <= 0. A coincident event is dropped.
  2. enable=1 & ev[i] & count[i] < MAXVAL: count[i] <= count[i]+1.
  3. Otherwise: count[i] holds. At MAXVAL it stays at MAXVAL; it never wraps.
- Latency: count reflects an event one clk after the event is sampled.
- sat[i]:
  - Set on the same edge at which count[i] becomes MAXVAL.
  - Sticky; cleared only by clear[i] or reset.
- any_sat: registered in the same cycle as sat, i.e. any_sat equals the OR of the next sat values.
- enable=0:
  - Events are lost, not queued.
  - A rising edge that occurs while disabled is not counted after enable returns high.
  - clear still operates while enable=0.
- Channels are fully independent. Simultaneous events on all channels each increment their own channel.
- Arithmetic is unsigned, WIDTH bits. Comparison against MAXVAL uses a WIDTH-bit constant.
- Elaboration must fail (or assert in simulation) if MAXVAL=0 or MAXVAL > 2**WIDTH-1.

Optional Feature:
Macro CNT_THRESH_EN.
- Defined:
  - Adds input thresh (WIDTH bits, shared by all channels) and output over (NCH bits).
  - over[i] is a one-cycle registered pulse, asserted in the cycle count[i] changes to a value equal to thresh.
  - No pulse while count[i] holds or is saturated.
  - No pulse when thresh=0.
  - A clear does not produce a pulse.
  - over resets to 0.
- Not defined: thresh and over do not exist. Logic and timing are identical to the base block.

Test Plan:
1. Hold reset=0 for 3 clks, then release with trig=0 -> count=0, sat=0, any_sat=0 throughout and for 10 clks after release.
2. WIDTH=2, MAXVAL=3, EDGE=1, enable=1; toggle trig[0] high and low every clk for 5 rising edges -> count[0] = 1,2,3,3,3 (one clk after each edge); sat[0]=1 and any_sat=1 from the third edge onward; other channels stay 0.
3. With count[0]=3 and sat[0]=1, assert clear[0] in the same cycle as a trig[0] rising edge -> next cycle count[0]=0, sat[0]=0; the following edge gives count[0]=1.
4. enable=0 during 3 edges on trig[1] -> count[1] unchanged. Raise enable while trig[1] is held high -> no increment until the next rising edge, then count[1]+1. With EDGE=0 and trig[2] high for 4 cycles -> count[2]=4.
5. With count[0]=2, drive reset low between clock edges -> count[0]=0 and sat=0 immediately, with no clk edge; after release, counting resumes from 0.
6. With CNT_THRESH_EN defined, thresh=2, edges on trig[3] -> over[3] pulses exactly one clk when count[3] becomes 2; no further pulse at 3 or while saturated. With thresh=0 -> over never asserts.
